// File: rtl/bufferram_pkg.sv
// Shared definitions for the buffer RAM arbiter.
// Holds the default RAM geometry, the requester tag carried along each read,
// and the fill-engine state encoding.
package bufferram_pkg;

    localparam int ADDR_W_DEF = 17;
    localparam int DATA_W_DEF = 16;

    // Owner of a read travelling through the RAM latency pipeline.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_A    = 2'd1,
        TAG_B    = 2'd2
    } req_tag_e;

    typedef enum logic [1:0] {
        FILL_IDLE = 2'd0,
        FILL_RUN  = 2'd1,
        FILL_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/bufferram_fill_engine.sv
// Fill engine: writes fill_value into len consecutive words starting at base
// (addresses wrap modulo 2^ADDR_W). It only requests; the arbiter decides when
// a write is taken and reports it back on grant.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start/base/len/value fill command, accepted only when idle
//   grant               the arbiter took the current fill write this cycle
//   req                 a fill write is pending
//   addr/data           target address and data of the pending write
//   busy                high in RUN and DONE
//   done                one-cycle pulse in DONE
module bufferram_fill_engine
    import bufferram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] len,
    input  logic [DATA_W-1:0] value,
    input  logic              grant,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              busy,
    output logic              done
);

    fill_state_e       state, state_next;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] value_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FILL_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            count   <= '0;
            value_q <= '0;
        end else begin
            state <= state_next;
            if (state == FILL_IDLE && start) begin
                base_q  <= base;
                len_q   <= len;
                value_q <= value;
                count   <= '0;
            end else if (grant) begin
                count <= count + ADDR_W'(1);
            end
        end
    end

    // RUN stays one extra cycle after the last grant (count reaches len while
    // that write is on the RAM bus), so done lands one cycle after it.
    always_comb begin
        // NOTE: every output gets a default first, so no path infers a latch.
        state_next = state;
        req        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            FILL_IDLE: begin
                if (start) state_next = (len == '0) ? FILL_DONE : FILL_RUN;
            end
            FILL_RUN: begin
                busy = 1'b1;
                req  = (count != len_q);
                if (count == len_q) state_next = FILL_DONE;
            end
            FILL_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = FILL_IDLE;
            end
            default: state_next = FILL_IDLE;
        endcase
    end

    assign addr = base_q + count;
    assign data = value_q;

endmodule

// File: rtl/bufferram_arbiter.sv
// Buffer RAM arbiter: shares one RAM port between a scanout reader (A), a CPU
// bridge (B) and a background fill engine. A and B are arbitrated round-robin;
// fill writes use only cycles where neither A nor B is requesting. All RAM
// master outputs are registered; reads return RD_LAT cycles after they appear
// on the RAM bus, routed to their owner by a tag pipeline.
// Ports:
//   clk_clk, reset_reset_n        clock, asynchronous active-low reset
//   a_*                           read-only requester (valid/ready, rvalid/rdata)
//   b_*                           read/write requester with byte enables
//   fill_*                        fill command and busy/done status
//   m_*                           RAM master port
// RD_LAT must be in 1..3.
module bufferram_arbiter
    import bufferram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_address,
    output logic                a_rvalid,
    output logic [DATA_W-1:0]   a_rdata,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic                b_write,
    input  logic [ADDR_W-1:0]   b_address,
    input  logic [DATA_W-1:0]   b_writedata,
    input  logic [DATA_W/8-1:0] b_byteenable,
    output logic                b_rvalid,
    output logic [DATA_W-1:0]   b_rdata,
    input  logic                fill_start,
    input  logic [ADDR_W-1:0]   fill_base,
    input  logic [ADDR_W-1:0]   fill_len,
    input  logic [DATA_W-1:0]   fill_value,
    output logic                fill_busy,
    output logic                fill_done,
    output logic [ADDR_W-1:0]   m_address,
    output logic                m_chipselect,
    output logic                m_clken,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic [DATA_W/8-1:0] m_byteenable,
    input  logic [DATA_W-1:0]   m_readdata
);

    logic              last_b;     // B won the most recent A/B grant
    logic              a_gnt, b_gnt, f_gnt;
    logic              fill_req;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    req_tag_e          issue_tag;  // owner of the read now on m_*
    req_tag_e          tag_pipe [RD_LAT];

    bufferram_fill_engine #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fill (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .start (fill_start),
        .base  (fill_base),
        .len   (fill_len),
        .value (fill_value),
        .grant (f_gnt),
        .req   (fill_req),
        .addr  (fill_addr),
        .data  (fill_data),
        .busy  (fill_busy),
        .done  (fill_done)
    );

    // Readies are the grants themselves; gating with reset keeps them low
    // while the block is held in reset.
    always_comb begin
        a_gnt = reset_reset_n && a_valid && (!b_valid || last_b);
        b_gnt = reset_reset_n && b_valid && (!a_valid || !last_b);
        f_gnt = reset_reset_n && fill_req && !a_valid && !b_valid;
    end

    assign a_ready = a_gnt;
    assign b_ready = b_gnt;

    // Address, write data and byte enables hold between accesses; reads leave
    // the write data untouched.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            last_b       <= 1'b1;
            m_clken      <= 1'b0;
            m_chipselect <= 1'b0;
            m_write      <= 1'b0;
            m_address    <= '0;
            m_writedata  <= '0;
            m_byteenable <= '0;
            issue_tag    <= TAG_NONE;
        end else begin
            m_clken      <= 1'b1;
            m_chipselect <= a_gnt || b_gnt || f_gnt;
            m_write      <= 1'b0;
            issue_tag    <= TAG_NONE;
            if (a_gnt) begin
                last_b       <= 1'b0;
                m_address    <= a_address;
                m_byteenable <= '1;
                issue_tag    <= TAG_A;
            end else if (b_gnt) begin
                last_b       <= 1'b1;
                m_address    <= b_address;
                m_write      <= b_write;
                m_byteenable <= b_byteenable;
                if (b_write) m_writedata <= b_writedata;
                else         issue_tag   <= TAG_B;
            end else if (f_gnt) begin
                m_address    <= fill_addr;
                m_write      <= 1'b1;
                m_writedata  <= fill_data;
                m_byteenable <= '1;
            end
        end
    end

    // NOTE: the tag pipeline is reset (unlike a data memory) because a stale
    // tag surviving reset would raise an rvalid for a dropped read.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < RD_LAT; i++) tag_pipe[i] <= TAG_NONE;
        end else begin
            tag_pipe[0] <= issue_tag;
            for (int i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
        end
    end

    assign a_rvalid = (tag_pipe[RD_LAT-1] == TAG_A);
    assign b_rvalid = (tag_pipe[RD_LAT-1] == TAG_B);
    assign a_rdata  = a_rvalid ? m_readdata : '0;
    assign b_rdata  = b_rvalid ? m_readdata : '0;

endmodule

// File: doc/bufferram_arbiter.md
BUFFERRAM_ARBITER -- requirements
Module: bufferram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 17, buffer RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, buffer RAM data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter RD_LAT, default 1, buffer RAM read latency in cycles (1..3).
REQ-004 SHALL have ports: clk_clk  in  1  single clock; reset_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have requester A (read-only scanout) ports: a_valid in 1; a_ready out 1; a_address in ADDR_W; a_rvalid out 1; a_rdata out DATA_W.
REQ-006 SHALL have requester B (CPU/PIO bridge) ports: b_valid in 1; b_ready out 1; b_write in 1; b_address in ADDR_W; b_writedata in DATA_W; b_byteenable in DATA_W/8; b_rvalid out 1; b_rdata out DATA_W.
REQ-007 SHALL have fill-engine ports: fill_start in 1; fill_base in ADDR_W; fill_len in ADDR_W (words); fill_value in DATA_W; fill_busy out 1; fill_done out 1 (pulse).
REQ-008 SHALL have RAM master ports: m_address out ADDR_W; m_chipselect out 1; m_clken out 1; m_write out 1; m_writedata out DATA_W; m_byteenable out DATA_W/8; m_readdata in DATA_W.

Function
REQ-009 SHALL grant at most one access per cycle; a handshake is valid&&ready on the same cycle.
REQ-010 SHALL drive a_ready/b_ready combinationally as that requester's grant in the current cycle.
REQ-011 SHALL arbitrate A vs B round-robin: both valid -> grant the one not granted last; pointer updates only on an A or B grant; pointer resets to "B last" (A wins first tie).
REQ-012 SHALL issue fill writes only in cycles where neither a_valid nor b_valid is asserted.
REQ-013 SHALL register all m_* outputs: handshake in cycle N -> access on m_* in cycle N+1.
REQ-014 SHALL assert m_chipselect only in access cycles; m_write=0 outside write accesses; m_address/m_writedata/m_byteenable hold last value when idle.
REQ-015 SHALL force m_byteenable to all-ones for A reads and fill writes; B byteenable passes through.
REQ-016 SHALL track each read with a requester tag in an RD_LAT-deep shift pipeline; read issued on m_* in cycle N+1 -> rvalid of owner asserted in cycle N+1+RD_LAT with rdata = m_readdata (combinational).
REQ-017 SHALL never assert a_rvalid and b_rvalid in the same cycle; writes produce no rvalid.
REQ-018 SHALL support back-to-back accesses with no bubble (one access per cycle sustained).
REQ-019 Fill FSM states: IDLE, RUN, DONE.
REQ-020 IDLE: fill_start=1 and fill_len!=0 latches base/len/value, goes RUN; fill_start with fill_len=0 goes DONE with zero writes.
REQ-021 RUN: each issued fill write targets base+count modulo 2^ADDR_W (wrap-around), count increments; after fill_len writes -> DONE.
REQ-022 DONE: fill_done=1 for exactly one cycle, then IDLE.
REQ-023 SHALL assert fill_busy in RUN and DONE; fill_start while busy SHALL be ignored.
REQ-024 SHALL hold m_clken=1 at all times after reset deassertion.

Reset
REQ-025 While reset_reset_n=0: m_chipselect, m_write, m_clken, a_ready, b_ready, a_rvalid, b_rvalid, fill_busy, fill_done = 0; m_address, m_writedata, a_rdata/b_rdata register paths = 0; m_byteenable = 0; FSM IDLE; tag pipeline cleared.
REQ-026 Reset mid-operation SHALL drop in-flight reads (no rvalid afterwards) and abort fill without fill_done.

Structure
REQ-027 Shared package bufferram_pkg SHALL hold ADDR_W/DATA_W defaults, requester tag enum (TAG_NONE, TAG_A, TAG_B) and fill-state enum.
REQ-028 Fill FSM/counter SHALL be sub-module bufferram_fill_engine; arbitration, output registers and tag pipeline stay in top.

Verification
REQ-029 A reads 0x00010, B idle, RD_LAT=1 -> m_chipselect cycle N+1 address 0x00010, a_rvalid cycle N+2, a_rdata = RAM content.
REQ-030 A and B valid continuously 6 cycles -> grants alternate A,B,A,B,A,B; no cycle with both ready.
REQ-031 Fill base 0x1FFFE, len 4, value 0xA5A5, no traffic -> writes 0x1FFFE,0x1FFFF,0x00000,0x00001 with byteenable 2'b11; fill_done one cycle after last write.
REQ-032 Fill len 0x100 while B writes every other cycle -> fill writes only in B-idle cycles, total 0x100, B data intact.
REQ-033 fill_start with fill_len 0 -> no m_chipselect, fill_done pulse next cycle; fill_start during RUN -> ignored.
REQ-034 reset_reset_n low with A read in flight and fill RUN -> all outputs at reset values, no a_rvalid or fill_done after release.
